regfile_dump_reader: RTL
========================

// Module: regfile_dump_reader
// PURPOSE
// - Debug/trace reader for the 32x32 register file: on a start pulse, walks
//   every register index through one regfile read port and streams each word
//   out over a valid/ready interface.
// - Sits beside the core. It owns one read port (ra/rd) of the register file
//   while busy. The debug transport (UART/JTAG shim) consumes the stream.
// PARAMETERS
// - XLEN      32  data width of one register word
// - NUM_REGS  32  number of registers dumped, indices 0..NUM_REGS-1
// - ADDR_W    5   index width; must satisfy 2**ADDR_W >= NUM_REGS
// PORTS
// - clk          in   1       clock, rising edge
// - rst_n        in   1       asynchronous, active-low reset
// - start        in   1       1-cycle request to begin a dump; ignored while busy
// - rf_ra        out  ADDR_W  read address to regfile read port (registered)
// - rf_rd        in   XLEN    combinational read data from regfile for rf_ra
// - out_valid    out  1       stream beat valid
// - out_ready    in   1       stream sink ready
// - out_data     out  XLEN    beat payload
// - out_idx      out  ADDR_W  register index of beat (0 on checksum beat)
// - out_last     out  1       final beat of the dump
// - out_csum     out  1       beat is the checksum beat (0 when feature absent)
// - busy         out  1       dump in progress (FETCH/SEND/CSUM)
// - done         out  1       1-cycle pulse after the final beat handshakes
// BEHAVIOUR
// - Reset: state=IDLE; rf_ra=0, out_valid=0, out_data=0, out_idx=0,
//   out_last=0, out_csum=0, busy=0, done=0, idx=0, csum=0. Reset mid-dump
//   aborts at once. There is no partial completion, and no done pulse is issued.
// - FSM states: IDLE, FETCH, SEND, CSUM (CSUM only with the macro).
// - IDLE: start=1 -> FETCH, idx<=0, rf_ra<=0, csum<=0. Otherwise stay.
// - FETCH (1 cycle): rf_rd for rf_ra is captured into out_data.
//   Also out_idx<=idx, out_valid<=1, out_last<=(idx==NUM_REGS-1 && !csum beat
//   pending). -> SEND.
// - SEND: hold out_valid/out_data/out_idx/out_last stable until out_ready=1.
//   * On handshake with idx<NUM_REGS-1: out_valid<=0, idx<=idx+1, rf_ra<=idx+1.
//     Go to FETCH.
//   * On handshake with idx==NUM_REGS-1: go to CSUM if the macro is present.
//     Otherwise go to IDLE with done<=1 for one cycle.
// - Latency: start at cycle T -> rf_ra=0 from T+1, first out_valid at T+2.
//   Steady state is 1 beat per 2 cycles with out_ready held high.
// - out_valid never drops without a handshake. Payload never changes while
//   out_valid=1 && out_ready=0.
// - start during busy is ignored and does not restart. start on the same cycle
//   as done is accepted, because the FSM is then in IDLE-next.
// - Index 0 is read through the port like any other; the regfile returns 0.
// - Coherency: each word reflects regfile contents at its FETCH cycle. Writes
//   to an index before its FETCH are visible; writes after it are not.
// - idx does not wrap; the dump terminates at NUM_REGS-1.
// - busy=1 in FETCH, SEND and CSUM. rf_ra is held at the last index after the
//   dump.
// CONFIGURATION
// - REGDUMP_CHECKSUM_EN defined:
//   * csum <= csum ^ rf_rd on each FETCH.
//   * After the last register beat (out_last=0 on it), CSUM presents one extra
//     beat: out_data=csum, out_idx=0, out_csum=1, out_last=1.
//   * The CSUM handshake -> IDLE with done pulse. Total beats: NUM_REGS+1.
// - Not defined: no CSUM state and no csum register. out_csum tied 0.
//   out_last=1 on index NUM_REGS-1. Total beats: NUM_REGS.
// TESTING
// - Preload xN=N*0x11111111 (x0=0), start, out_ready=1:
//   * 32 beats, idx 0..31, data match, out_last only on idx31.
//   * First valid at T+2; done 1 cycle after the last handshake.
// - Random out_ready backpressure (50%): payload stable while stalled, no
//   beats lost or duplicated, order strictly 0..31.
// - start pulsed at beat 5 while busy: ignored, dump completes with 32 beats.
//   Back-to-back start on the done cycle runs a second full dump.
// - rst_n asserted during SEND of idx 10: all outputs to reset values next
//   cycle, no done pulse. Fresh start dumps from idx 0.
// - Write x20=0xDEADBEEF while dumping idx 3: beat 20 = 0xDEADBEEF.
//   Write x2 at the same time: beat 2 keeps its old value.
// - With REGDUMP_CHECKSUM_EN, preload as in test 1:
//   * 33rd beat has out_csum=1, out_last=1, data = XOR of x1..x31.
//   * idx31 beat has out_last=0.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks every regfile index through one read port and streams
// the words out over valid/ready. Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat.
module regfile_dump_reader #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rf_ra,
   input  logic [XLEN-1:0]   rf_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              out_last,
   output logic              out_csum,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND
`ifdef REGDUMP_CHECKSUM_EN
      , CSUM
`endif
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_ra;
   logic [XLEN-1:0]   r_data;
   logic [ADDR_W-1:0] r_oidx;
   logic              r_valid;
   logic              r_last;
   logic              r_done;
   logic              w_hs;
   logic              w_at_last;
`ifdef REGDUMP_CHECKSUM_EN
   logic [XLEN-1:0]   r_csum;
   logic              r_csum_beat;
`endif

   assign w_hs      = r_valid & out_ready;
   assign w_at_last = (r_idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (start) w_next = FETCH;
         FETCH: w_next = SEND;
         SEND: begin
            if (w_hs) begin
               if (!w_at_last) w_next = FETCH;
`ifdef REGDUMP_CHECKSUM_EN
               else            w_next = CSUM;
`else
               else            w_next = IDLE;
`endif
            end
         end
`ifdef REGDUMP_CHECKSUM_EN
         CSUM:  if (w_hs) w_next = IDLE;
`endif
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != IDLE);
      rf_ra     = r_ra;
      out_valid = r_valid;
      out_data  = r_data;
      out_idx   = r_oidx;
      out_last  = r_last;
      done      = r_done;
`ifdef REGDUMP_CHECKSUM_EN
      out_csum  = r_csum_beat;
`else
      out_csum  = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_ra        <= '0;
         r_data      <= '0;
         r_oidx      <= '0;
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
         r_done      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
         r_csum      <= '0;
         r_csum_beat <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_idx <= '0;
                  r_ra  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
                  r_csum <= '0;
`endif
               end
            end
            FETCH: begin
               r_data  <= rf_rd;
               r_oidx  <= r_idx;
               r_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
               r_last  <= 1'b0;
               r_csum  <= r_csum ^ rf_rd;
`else
               r_last  <= w_at_last;
`endif
            end
            SEND: begin
               if (w_hs) begin
                  if (!w_at_last) begin
                     r_valid <= 1'b0;
                     r_idx   <= r_idx + ADDR_W'(1);
                     r_ra    <= r_idx + ADDR_W'(1);
                  end else begin
`ifdef REGDUMP_CHECKSUM_EN
                     // valid stays high: the checksum beat follows with no gap
                     r_data      <= r_csum;
                     r_oidx      <= '0;
                     r_last      <= 1'b1;
                     r_csum_beat <= 1'b1;
`else
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_done  <= 1'b1;
`endif
                  end
               end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: begin
               if (w_hs) begin
                  r_valid     <= 1'b0;
                  r_last      <= 1'b0;
                  r_csum_beat <= 1'b0;
                  r_done      <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
